// File: rtl/ring_link_arbiter.sv
// Packet-level round-robin arbiter sharing one downstream ring link between
// upstream through-traffic and local NI injection, with one registered output stage.
module ring_link_arbiter #(
  parameter int FLIT_W    = 8,
  parameter int PKT_FLITS = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] flit_in_up,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [FLIT_W-1:0] flit_in_NI,
  input  logic              ni_valid,
  output logic              ni_ready,
  output logic [FLIT_W-1:0] flit_out_down,
  output logic              down_valid,
  input  logic              down_ready,
  output logic [1:0]        grant,
  output logic              pkt_done
);

  localparam int CNT_W = (PKT_FLITS > 2) ? $clog2(PKT_FLITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PKT_FLITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // State encoding doubles as the grant output: bit0 = UP, bit1 = NI.
  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_LOCK_UP = 2'b01,
    S_LOCK_NI = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_ni_q, last_ni_d;
  logic [FLIT_W-1:0] flit_q, flit_d;
  logic              dvalid_q, dvalid_d;
  logic              pkt_done_q, pkt_done_d;

  logic              can_accept;
  logic              sel_up, sel_ni;
  logic              up_xfer, ni_xfer, in_xfer;
  logic [FLIT_W-1:0] in_flit;

  assign can_accept = !dvalid_q || down_ready;

  // IDLE picks combinationally so a new packet can follow the previous one with no bubble.
  always_comb begin
    sel_up = 1'b0;
    sel_ni = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (up_valid && (!ni_valid || last_ni_q)) begin
          sel_up = 1'b1;
        end else if (ni_valid) begin
          sel_ni = 1'b1;
        end
      end
      S_LOCK_UP: sel_up = 1'b1;
      S_LOCK_NI: sel_ni = 1'b1;
      default: begin
        sel_up = 1'b0;
        sel_ni = 1'b0;
      end
    endcase
  end

  always_comb begin
    up_ready = !rst && can_accept && sel_up;
    ni_ready = !rst && can_accept && sel_ni;
  end

  assign up_xfer = up_valid && up_ready;
  assign ni_xfer = ni_valid && ni_ready;
  assign in_xfer = up_xfer || ni_xfer;
  assign in_flit = up_xfer ? flit_in_up : flit_in_NI;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_ni_d  = last_ni_q;
    pkt_done_d = 1'b0;
    if (in_xfer) begin
      if (state_q == S_IDLE) begin
        state_d = up_xfer ? S_LOCK_UP : S_LOCK_NI;
        cnt_d   = CNT_ONE;
      end else if (cnt_q == CNT_LAST) begin
        state_d    = S_IDLE;
        cnt_d      = '0;
        last_ni_d  = (state_q == S_LOCK_NI);
        pkt_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_comb begin
    flit_d   = flit_q;
    dvalid_d = dvalid_q;
    if (can_accept) begin
      dvalid_d = in_xfer;
      if (in_xfer) begin
        flit_d = in_flit;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_ni_q  <= 1'b1;
      flit_q     <= '0;
      dvalid_q   <= 1'b0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_ni_q  <= last_ni_d;
      flit_q     <= flit_d;
      dvalid_q   <= dvalid_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  assign grant         = state_q;
  assign flit_out_down = flit_q;
  assign down_valid    = dvalid_q;
  assign pkt_done      = pkt_done_q;

endmodule

// File: tb/tb_ring_link_arbiter.sv
// Directed bench for ring_link_arbiter: reset, streaming, contest, back-pressure,
// owner stall and mid-packet reset.
module tb_ring_link_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] flit_in_up, flit_in_NI, flit_out_down;
  logic       up_valid, up_ready, ni_valid, ni_ready;
  logic       down_valid, down_ready, pkt_done;
  logic [1:0] grant;

  int checks = 0;
  int errors = 0;

  ring_link_arbiter #(.FLIT_W(8), .PKT_FLITS(5)) dut (
    .clk(clk), .rst(rst),
    .flit_in_up(flit_in_up), .up_valid(up_valid), .up_ready(up_ready),
    .flit_in_NI(flit_in_NI), .ni_valid(ni_valid), .ni_ready(ni_ready),
    .flit_out_down(flit_out_down), .down_valid(down_valid), .down_ready(down_ready),
    .grant(grant), .pkt_done(pkt_done)
  );

  always #5 clk = ~clk;

  task automatic edge1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; up_valid = 1'b0; ni_valid = 1'b0; down_ready = 1'b1;
    flit_in_up = 8'h00; flit_in_NI = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; up_valid = 1'b1; ni_valid = 1'b1; down_ready = 1'b1;
    flit_in_up = 8'h55; flit_in_NI = 8'h66;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++; if (up_ready !== 1'b0) begin errors++; $display("FAIL rst_up_ready got %b want 0", up_ready); end
    checks++; if (ni_ready !== 1'b0) begin errors++; $display("FAIL rst_ni_ready got %b want 0", ni_ready); end
    checks++; if (down_valid !== 1'b0) begin errors++; $display("FAIL rst_down_valid got %b want 0", down_valid); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant got %b want 00", grant); end
    checks++; if (flit_out_down !== 8'h00) begin errors++; $display("FAIL rst_flit got %h want 00", flit_out_down); end
    checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL rst_pkt_done got %b want 0", pkt_done); end
    up_valid = 1'b0; ni_valid = 1'b0;
    #1 rst = 1'b0;
  endtask

  task automatic test_up_stream;
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exp = 8'(8'h10 + i);
      flit_in_up = exp; up_valid = 1'b1;
      #1;
      checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL up_stream_ready[%0d] got %b want 1", i, up_ready); end
      checks++; if (ni_ready !== 1'b0) begin errors++; $display("FAIL up_stream_ni_ready[%0d] got %b want 0", i, ni_ready); end
      edge1();
      checks++; if (flit_out_down !== exp || down_valid !== 1'b1) begin errors++; $display("FAIL up_stream_out[%0d] got %h/%b want %h/1", i, flit_out_down, down_valid, exp); end
      checks++; if (grant !== ((i < 4) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL up_stream_grant[%0d] got %b want %b", i, grant, (i < 4) ? 2'b01 : 2'b00); end
      checks++; if (pkt_done !== (i == 4)) begin errors++; $display("FAIL up_stream_pkt_done[%0d] got %b want %b", i, pkt_done, i == 4); end
    end
    up_valid = 1'b0;
    edge1();
    checks++; if (down_valid !== 1'b0) begin errors++; $display("FAIL up_stream_drain got %b want 0", down_valid); end
    checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL up_stream_pulse_width got %b want 0", pkt_done); end
  endtask

  task automatic test_contest;
    int ui, nj;
    logic owner_up;
    logic [7:0] exp;
    logic [1:0] exp_grant;
    do_reset();
    ui = 0; nj = 0;
    for (int k = 0; k < 20; k++) begin
      flit_in_up = 8'(8'hA0 + ui); up_valid = (ui < 10);
      flit_in_NI = 8'(8'hB0 + nj); ni_valid = (nj < 10);
      #1;
      owner_up = ((k / 5) % 2 == 0);
      checks++; if (up_ready !== owner_up || ni_ready !== !owner_up) begin errors++; $display("FAIL contest_ready[%0d] got up=%b ni=%b want up=%b ni=%b", k, up_ready, ni_ready, owner_up, !owner_up); end
      if (owner_up) begin exp = 8'(8'hA0 + ui); ui++; end
      else begin exp = 8'(8'hB0 + nj); nj++; end
      exp_grant = (k % 5 == 4) ? 2'b00 : (owner_up ? 2'b01 : 2'b10);
      edge1();
      checks++; if (flit_out_down !== exp || down_valid !== 1'b1) begin errors++; $display("FAIL contest_out[%0d] got %h/%b want %h/1", k, flit_out_down, down_valid, exp); end
      checks++; if (grant !== exp_grant) begin errors++; $display("FAIL contest_grant[%0d] got %b want %b", k, grant, exp_grant); end
    end
    up_valid = 1'b0; ni_valid = 1'b0;
    edge1();
  endtask

  task automatic test_backpressure;
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp = 8'(8'hC0 + i);
      flit_in_NI = exp; ni_valid = 1'b1;
      #1;
      checks++; if (ni_ready !== 1'b1) begin errors++; $display("FAIL bp_ni_ready[%0d] got %b want 1", i, ni_ready); end
      edge1();
      checks++; if (flit_out_down !== exp) begin errors++; $display("FAIL bp_out[%0d] got %h want %h", i, flit_out_down, exp); end
    end
    flit_in_NI = 8'hC3; up_valid = 1'b1; flit_in_up = 8'hD0; down_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      checks++; if (ni_ready !== 1'b0 || up_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready[%0d] got ni=%b up=%b want 0/0", s, ni_ready, up_ready); end
      edge1();
      checks++; if (flit_out_down !== 8'hC2 || down_valid !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d] got %h/%b want c2/1", s, flit_out_down, down_valid); end
      checks++; if (grant !== 2'b10) begin errors++; $display("FAIL bp_grant[%0d] got %b want 10", s, grant); end
    end
    down_ready = 1'b1;
    for (int i = 3; i < 5; i++) begin
      exp = 8'(8'hC0 + i);
      flit_in_NI = exp;
      #1;
      checks++; if (ni_ready !== 1'b1 || up_ready !== 1'b0) begin errors++; $display("FAIL bp_resume_ready[%0d] got ni=%b up=%b want 1/0", i, ni_ready, up_ready); end
      edge1();
      checks++; if (flit_out_down !== exp) begin errors++; $display("FAIL bp_resume_out[%0d] got %h want %h", i, flit_out_down, exp); end
      checks++; if (pkt_done !== (i == 4)) begin errors++; $display("FAIL bp_pkt_done[%0d] got %b want %b", i, pkt_done, i == 4); end
    end
    up_valid = 1'b0; ni_valid = 1'b0;
    edge1();
  endtask

  task automatic test_ni_stall;
    logic [7:0] exp;
    do_reset();
    flit_in_NI = 8'hE0; ni_valid = 1'b1;
    #1;
    checks++; if (ni_ready !== 1'b1) begin errors++; $display("FAIL stall_head_ready got %b want 1", ni_ready); end
    edge1();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL stall_grant_head got %b want 10", grant); end
    up_valid = 1'b1; flit_in_up = 8'hD1; flit_in_NI = 8'hE1;
    #1;
    checks++; if (up_ready !== 1'b0) begin errors++; $display("FAIL stall_up_ready_e1 got %b want 0", up_ready); end
    edge1();
    checks++; if (flit_out_down !== 8'hE1) begin errors++; $display("FAIL stall_out_e1 got %h want e1", flit_out_down); end
    ni_valid = 1'b0;
    for (int s = 0; s < 2; s++) begin
      #1;
      checks++; if (up_ready !== 1'b0) begin errors++; $display("FAIL stall_gap_up_ready[%0d] got %b want 0", s, up_ready); end
      edge1();
      checks++; if (grant !== 2'b10 || down_valid !== 1'b0) begin errors++; $display("FAIL stall_gap_state[%0d] got grant=%b dv=%b want 10/0", s, grant, down_valid); end
    end
    ni_valid = 1'b1;
    for (int i = 2; i < 5; i++) begin
      exp = 8'(8'hE0 + i);
      flit_in_NI = exp;
      #1;
      checks++; if (up_ready !== 1'b0 || ni_ready !== 1'b1) begin errors++; $display("FAIL stall_resume_ready[%0d] got up=%b ni=%b want 0/1", i, up_ready, ni_ready); end
      edge1();
      checks++; if (flit_out_down !== exp || down_valid !== 1'b1) begin errors++; $display("FAIL stall_resume_out[%0d] got %h/%b want %h/1", i, flit_out_down, down_valid, exp); end
      checks++; if (pkt_done !== (i == 4)) begin errors++; $display("FAIL stall_pkt_done[%0d] got %b want %b", i, pkt_done, i == 4); end
    end
    ni_valid = 1'b0;
    #1;
    checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL stall_up_after got %b want 1", up_ready); end
    up_valid = 1'b0;
    edge1();
  endtask

  task automatic test_reset_mid;
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      flit_in_up = 8'(8'hF0 + i); up_valid = 1'b1;
      edge1();
    end
    checks++; if (flit_out_down !== 8'hF2 || grant !== 2'b01) begin errors++; $display("FAIL mid_pre got %h/%b want f2/01", flit_out_down, grant); end
    flit_in_up = 8'hF3; flit_in_NI = 8'h77; ni_valid = 1'b1;
    #1 rst = 1'b1;
    #1;
    checks++; if (down_valid !== 1'b0 || flit_out_down !== 8'h00) begin errors++; $display("FAIL mid_out_clear got %h/%b want 00/0", flit_out_down, down_valid); end
    checks++; if (grant !== 2'b00 || pkt_done !== 1'b0) begin errors++; $display("FAIL mid_state_clear got grant=%b done=%b want 00/0", grant, pkt_done); end
    checks++; if (up_ready !== 1'b0 || ni_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_forced got up=%b ni=%b want 0/0", up_ready, ni_ready); end
    edge1();
    rst = 1'b0; up_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp = 8'(8'h90 + i);
      flit_in_NI = exp; ni_valid = 1'b1;
      #1;
      checks++; if (ni_ready !== 1'b1) begin errors++; $display("FAIL mid_ni_ready[%0d] got %b want 1", i, ni_ready); end
      edge1();
      checks++; if (flit_out_down !== exp) begin errors++; $display("FAIL mid_ni_out[%0d] got %h want %h", i, flit_out_down, exp); end
      checks++; if (grant !== ((i < 4) ? 2'b10 : 2'b00) || pkt_done !== (i == 4)) begin errors++; $display("FAIL mid_ni_pkt[%0d] got grant=%b done=%b want %b/%b", i, grant, pkt_done, (i < 4) ? 2'b10 : 2'b00, i == 4); end
    end
    ni_valid = 1'b0;
    edge1();
  endtask

  initial begin
    test_reset();
    test_up_stream();
    test_contest();
    test_backpressure();
    test_ni_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ring_link_arbiter.md
# ring_link_arbiter

Packet-level arbiter for a node's single downstream ring link. It shares `flit_out_down` between through-traffic arriving on the upstream ring port and locally injected flits from the network interface. A grant is held for a whole fixed-length packet, and ownership then alternates round-robin. Output is one registered pipeline stage with valid/ready flow control. The block sits between the NI flit output and the router's down port inside a node.

## Interface
- `FLIT_W`, 8: flit width in bits.
- `PKT_FLITS`, 5: flits per packet (head + 4 payload); must be ≥2.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `flit_in_up`  in  FLIT_W: through-traffic flit from the upstream neighbour.
- `up_valid`  in  1: `flit_in_up` is valid.
- `up_ready`  out  1: arbiter accepts `flit_in_up` this cycle.
- `flit_in_NI`  in  FLIT_W: locally injected flit from the NI.
- `ni_valid`  in  1: `flit_in_NI` is valid.
- `ni_ready`  out  1: arbiter accepts `flit_in_NI` this cycle; drives the NI's `noc_ready`.
- `flit_out_down`  out  FLIT_W: registered flit to the downstream link.
- `down_valid`  out  1: `flit_out_down` holds a valid flit.
- `down_ready`  in  1: downstream accepts `flit_out_down` this cycle.
- `grant`  out  2: registered lock owner; bit0 = UP, bit1 = NI, 00 = idle. Never 11.
- `pkt_done`  out  1: one-cycle registered pulse after the last flit of a packet is accepted from either source.

## Operation
- Transfer definitions:
  - Input transfer: `src_valid && src_ready` at a rising edge.
  - Output transfer: `down_valid && down_ready`.
- `can_accept = !down_valid || down_ready`. This is combinational, giving 1 flit/cycle throughput.
- States:
  - IDLE (`grant`=00).
  - LOCK_UP (01).
  - LOCK_NI (10).
- IDLE selection is combinational:
  - Only one source valid: select it.
  - Both valid: select the source not named by `last`.
  - `last` resets to NI, so UP wins the first contest.
- Ready rule: `src_ready = can_accept && (selected in IDLE, or owner in LOCK)`. The non-owner's ready is always 0.
- Counter `cnt` (width `$clog2(PKT_FLITS)`) counts input transfers of the current packet.
- Transitions on an input transfer:
  - From IDLE: go to LOCK_<src> with `cnt`=1.
  - In LOCK: `cnt`+1.
  - When the transfer is the flit with `cnt`==PKT_FLITS-1: go to IDLE, set `cnt`=0, set `last`=owner, pulse `pkt_done` next cycle.
- No transfer: state, `cnt` and `last` hold. A locked owner deasserting valid mid-packet stalls the link. The other source is never granted until the packet completes, so no interleaving ever occurs.
- Output register loads the accepted flit when `can_accept`.
- If `down_ready` is high and no input transfer occurs, `down_valid` clears.
- Flits pass unmodified. No head decoding: the arbiter relies only on `PKT_FLITS`.

## Timing
- Reset (async, while `rst`=1):
  - State IDLE, `cnt`=0, `last`=NI.
  - `flit_out_down`=0, `down_valid`=0, `grant`=00, `pkt_done`=0.
  - `up_ready`=0 and `ni_ready`=0 are forced while `rst`=1.
- Latency: a flit accepted at edge N is on `flit_out_down` with `down_valid`=1 after edge N.
- Packet turnaround has zero bubbles. The last flit of packet A and the head of packet B (other source) transfer on consecutive edges, because IDLE selection is combinational.
- Back-pressure:
  - `down_ready`=0 with `down_valid`=1 holds `flit_out_down` stable.
  - All input readies are 0 under this back-pressure.
- Simultaneous head arrival from both sources in IDLE: one grant per `last`. The loser's ready stays 0 for the full packet plus stalls.
- Reset mid-packet:
  - The partial packet is abandoned and the output flit is dropped.
  - After release, arbitration restarts from IDLE with UP priority.

## Test plan
- Reset check: assert `rst` with both sources valid -> both readies 0; `down_valid`=0, `grant`=00, `flit_out_down`=0.
- UP streams flits 0x10..0x14 with `down_ready`=1 -> `flit_out_down` shows 0x10..0x14 on 5 consecutive cycles, each one cycle after acceptance; `pkt_done` pulses once; `grant`=01 for 4 cycles after the first transfer.
- UP and NI both valid from cycle 0 with streams 0xA0..0xA4 and 0xB0..0xB4 -> output is A0..A4 then B0..B4 with no gap and no interleave; on a second contest NI wins.
- `down_ready` held 0 for 3 cycles during flit 2 of an NI packet -> `flit_out_down` holds; `ni_ready`=0 and `up_ready`=0; the stream resumes in order.
- NI drops `ni_valid` for 2 cycles mid-packet while UP is valid -> `up_ready` stays 0; `grant` stays 10; the packet completes with 5 flits.
- `rst` pulsed after flit 3 of a UP packet -> outputs clear immediately; next NI-only packet is accepted from IDLE with `cnt` restarting at 0.
